// File: rtl/sr_drv_pkg.sv
// Shared FSM state and per-bit SR excitation encoding for the SR flip-flop bank driver.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Excitation is packed as {s, r}; no code has both bits set, so S and R stay exclusive.
    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        CLEAR = 2'b01,
        SET   = 2'b10
    } excite_t;

    function automatic excite_t excite_bit(
        input logic target,
        input logic mask,
        input logic q
    );
        excite_t code;
        code = HOLD;
        if (mask && target && !q) begin
            code = SET;
        end else if (mask && !target && q) begin
            code = CLEAR;
        end
        return code;
    endfunction

endpackage

// File: rtl/sr_excite.sv
// One bit of SR excitation: drive only the bits that are masked and differ from the readback.
module sr_excite
    import sr_drv_pkg::*;
(
    input  logic target,
    input  logic mask,
    input  logic q,
    output logic s,
    output logic r
);

    excite_t code;

    always_comb begin
        code = excite_bit(target, mask, q);
        s    = code[1];
        r    = code[0];
    end

endmodule

// File: rtl/sr_ff_driver.sv
// Writes masked target values into an external SR flip-flop bank, verifies the readback
// after a settle time and re-drives up to MAX_RETRY times before reporting an error.
module sr_ff_driver
    import sr_drv_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_RETRY  = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] req_mask,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] shadow
);

    // A zero-width counter is not legal, so MAX_RETRY = 0 still keeps one (always-zero) bit.
    localparam int RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int SW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_EFF - 1);

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] data_reg,   data_next;
    logic [WIDTH-1:0] mask_reg,   mask_next;
    logic [RW-1:0]    retry_reg,  retry_next;
    logic [SW-1:0]    settle_reg, settle_next;
    logic [WIDTH-1:0] s_reg,      s_next;
    logic [WIDTH-1:0] r_reg,      r_next;
    logic             done_reg,   done_next;
    logic             err_reg,    err_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;

    logic             accept;
    logic [WIDTH-1:0] exc_target;
    logic [WIDTH-1:0] exc_mask;
    logic [WIDTH-1:0] exc_s;
    logic [WIDTH-1:0] exc_r;

    assign req_ready = rst_n && (state_reg == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // S/R are loaded on the edge that enters DRIVE: from the live request when accepting,
    // from the captured request when re-driving out of CHECK.
    assign exc_target = (state_reg == ST_IDLE) ? req_data : data_reg;
    assign exc_mask   = (state_reg == ST_IDLE) ? req_mask : mask_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_excite
            sr_excite u_excite (
                .target (exc_target[gi]),
                .mask   (exc_mask[gi]),
                .q      (q_fb[gi]),
                .s      (exc_s[gi]),
                .r      (exc_r[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        mask_next   = mask_reg;
        retry_next  = retry_reg;
        settle_next = settle_reg;
        shadow_next = shadow_reg;
        s_next      = '0;
        r_next      = '0;
        done_next   = 1'b0;
        err_next    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    data_next  = req_data;
                    mask_next  = req_mask;
                    retry_next = '0;
                    if (req_mask == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_DRIVE;
                        s_next     = exc_s;
                        r_next     = exc_r;
                    end
                end
            end

            ST_DRIVE: begin
                state_next  = ST_SETTLE;
                settle_next = '0;
            end

            ST_SETTLE: begin
                if (settle_reg == SETTLE_LAST) begin
                    state_next = ST_CHECK;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end

            ST_CHECK: begin
                if ((q_fb & mask_reg) == (data_reg & mask_reg)) begin
                    done_next   = 1'b1;
                    shadow_next = q_fb;
                    state_next  = ST_IDLE;
                end else if (retry_reg != RETRY_LAST) begin
                    retry_next = retry_reg + 1'b1;
                    state_next = ST_DRIVE;
                    s_next     = exc_s;
                    r_next     = exc_r;
                end else begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            data_reg   <= '0;
            mask_reg   <= '0;
            retry_reg  <= '0;
            settle_reg <= '0;
            s_reg      <= '0;
            r_reg      <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            shadow_reg <= '0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            mask_reg   <= mask_next;
            retry_reg  <= retry_next;
            settle_reg <= settle_next;
            s_reg      <= s_next;
            r_reg      <= r_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            shadow_reg <= shadow_next;
        end
    end

    assign s      = s_reg;
    assign r      = r_reg;
    assign done   = done_reg;
    assign err    = err_reg;
    assign shadow = shadow_reg;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver driving a behavioural SR flip-flop bank model.
module tb_sr_ff_driver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [WIDTH-1:0] req_mask;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_fb;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] shadow;

    logic [WIDTH-1:0] bank;
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             stuck0;

    int checks = 0;
    int errors = 0;
    int s0_pulses = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    sr_ff_driver #(
        .WIDTH      (WIDTH),
        .MAX_RETRY  (3),
        .SETTLE_CYC (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .done      (done),
        .err       (err),
        .shadow    (shadow)
    );

    always #5 clk = ~clk;

    // Bank of posedge SR flip-flops; bit 0 can be held stuck at 0.
    always @(posedge clk) begin
        if (load_en) begin
            bank <= load_val;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] != r[i]) bank[i] <= s[i];
                else if (s[i] && r[i]) bank[i] <= 1'b0;
            end
        end
        if (stuck0) bank[0] <= 1'b0;
    end
    assign q_fb = bank;

    always @(negedge clk) begin
        checks++;
        if ((s & r) !== '0) begin
            errors++;
            $display("FAIL sr_exclusive: s&r=%h required 00", s & r);
        end
        if (s[0] === 1'b1) s0_pulses++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic test_reset();
        rst_n = 1'b1; req_valid = 1'b0; req_data = '0; req_mask = '0;
        load_en = 1'b1; load_val = 8'h00; stuck0 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h need 00", s); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_r: got %h need 00", r); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b need 0", err); end
        checks++; if (shadow !== 8'h00) begin errors++; $display("FAIL reset_shadow: got %h need 00", shadow); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b need 0", req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; load_en = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b need 1", req_ready); end
        $display("txn reset released ready=%b", req_ready);
    endtask

    task automatic test_full_write();
        req_valid = 1'b1; req_data = 8'hA5; req_mask = 8'hFF;
        @(negedge clk);
        // Garbage on the request bus after acceptance must be ignored.
        req_valid = 1'b0; req_data = 8'h00; req_mask = 8'hFF;
        checks++; if (s !== 8'hA5) begin errors++; $display("FAIL full_s: got %h need a5", s); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL full_r: got %h need 00", r); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_busy: got %b need 0", req_ready); end
        @(negedge clk);
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL full_s_one_cycle: got %h need 00", s); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_early: got %b need 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done_n4: got %b need 1", done); end
        checks++; if (shadow !== 8'hA5) begin errors++; $display("FAIL full_shadow: got %h need a5", shadow); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_done_ready: got %b need 1", req_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse: got %b need 0", done); end
        $display("txn full_write data=a5 mask=ff shadow=%h", shadow);
    endtask

    task automatic test_partial_write();
        req_valid = 1'b1; req_data = 8'h0F; req_mask = 8'hF0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL partial_s: got %h need 00", s); end
        checks++; if (r !== 8'hA0) begin errors++; $display("FAIL partial_r: got %h need a0", r); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL partial_done: got %b need 1", done); end
        checks++; if (shadow !== 8'h05) begin errors++; $display("FAIL partial_shadow: got %h need 05", shadow); end
        $display("txn partial_write data=0f mask=f0 shadow=%h", shadow);
    endtask

    task automatic test_stuck_retry();
        int cyc;
        stuck0 = 1'b1;
        repeat (2) @(negedge clk);
        s0_pulses = 0; done_cnt = 0; err_cnt = 0;
        req_valid = 1'b1; req_data = 8'h01; req_mask = 8'h01;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req_valid = 1'b0;
        end while (err !== 1'b1 && cyc < 40);
        checks++; if (cyc != 13) begin errors++; $display("FAIL stuck_err_cycle: got %0d need 13", cyc); end
        checks++; if (shadow !== 8'h05) begin errors++; $display("FAIL stuck_shadow: got %h need 05", shadow); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stuck_err_ready: got %b need 1", req_ready); end
        repeat (3) @(negedge clk);
        checks++; if (s0_pulses != 4) begin errors++; $display("FAIL stuck_pulses: got %0d need 4", s0_pulses); end
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL stuck_err_count: got %0d need 1", err_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL stuck_done_count: got %0d need 0", done_cnt); end
        $display("txn stuck_retry data=01 mask=01 s_pulses=%0d err=%0d", s0_pulses, err_cnt);
        stuck0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Bank holds 04 here: bit 0 was forced low by the previous scenario.
        req_valid = 1'b1; req_data = 8'hFF; req_mask = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (s !== 8'hFB) begin errors++; $display("FAIL mid_s: got %h need fb", s); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        done_cnt = 0; err_cnt = 0;
        checks++; if ({s, r} !== 16'h0000) begin errors++; $display("FAIL mid_rst_sr: got %h need 0000", {s, r}); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL mid_rst_pulse: got %b need 00", {done, err}); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b need 0", req_ready); end
        checks++; if (shadow !== 8'h00) begin errors++; $display("FAIL mid_rst_shadow: got %h need 00", shadow); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (done_cnt + err_cnt != 0) begin errors++; $display("FAIL mid_no_pulse: got %0d need 0", done_cnt + err_cnt); end
        req_valid = 1'b1; req_data = 8'h3C; req_mask = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (r !== 8'hC3) begin errors++; $display("FAIL mid_next_r: got %h need c3", r); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_next_done: got %b need 1", done); end
        checks++; if (shadow !== 8'h3C) begin errors++; $display("FAIL mid_next_shadow: got %h need 3c", shadow); end
        $display("txn reset_mid then data=3c mask=ff shadow=%h", shadow);
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_data = 8'hFF; req_mask = 8'h00;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b need 1", done); end
        checks++; if ({s, r} !== 16'h0000) begin errors++; $display("FAIL zero_sr: got %h need 0000", {s, r}); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b need 1", req_ready); end
        checks++; if (shadow !== 8'h3C) begin errors++; $display("FAIL zero_shadow: got %h need 3c", shadow); end
        $display("txn zero_mask data=ff mask=00 done=%b", done);
        req_data = 8'h5A; req_mask = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (s !== 8'h42) begin errors++; $display("FAIL b2b_s: got %h need 42", s); end
        checks++; if (r !== 8'h24) begin errors++; $display("FAIL b2b_r: got %h need 24", r); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %b need 0", done); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b need 1", done); end
        checks++; if (shadow !== 8'h5A) begin errors++; $display("FAIL b2b_shadow: got %h need 5a", shadow); end
        $display("txn back_to_back data=5a mask=ff shadow=%h", shadow);
        req_valid = 1'b1; req_data = 8'h00; req_mask = 8'h0F;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if ({s, r} !== 16'h000A) begin errors++; $display("FAIL b2b2_sr: got %h need 000a", {s, r}); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b2_done: got %b need 1", done); end
        checks++; if (shadow !== 8'h50) begin errors++; $display("FAIL b2b2_shadow: got %h need 50", shadow); end
        $display("txn back_to_back data=00 mask=0f shadow=%h", shadow);
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_write();
        test_stuck_retry();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
